// File: rtl/trap_sequencer.sv
// ---------------------------------------------------------------------------
// trap_sequencer
//   Owns the single csrfile write port. In IDLE it forwards the retiring CSR
//   instruction's write. On a trap it writes mepc, mcause (and mtval) in
//   successive cycles and then redirects to mtvec. On an mret it redirects
//   to mepc. The pipeline is flushed for as long as the sequencer is busy.
//
//   Optional feature macro: TRAP_SEQ_MTVAL_EN
//     defined   -> W_MTVAL state present, mtval written on every trap
//     undefined -> no tval latch, WB_TRAP_TVAL unused, mcause -> redirect
//
// Ports
//   CLK, RST_N          clock, asynchronous active-low reset
//   WB_TRAP_*           trap reported by the retiring instruction
//   WB_MRET             retiring mret
//   WB_CSR_WADDR/WDATA  CSR instruction write (address 0 = no write)
//   MTVEC, MEPC         current CSR values, used for redirect targets
//   CSR_WADDR/WDATA     csrfile write port (address 0 = no write)
//   BUSY, FLUSH         high in every non-IDLE state
//   REDIRECT_VALID/PC   one-cycle fetch redirect, PC is 0 when not valid
// ---------------------------------------------------------------------------
module trap_sequencer (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        WB_TRAP_VALID,
    input  logic [31:0] WB_TRAP_PC,
    input  logic [30:0] WB_TRAP_CAUSE,
    input  logic        WB_TRAP_IS_INT,
    input  logic [31:0] WB_TRAP_TVAL,
    input  logic        WB_MRET,
    input  logic [11:0] WB_CSR_WADDR,
    input  logic [31:0] WB_CSR_WDATA,
    input  logic [31:0] MTVEC,
    input  logic [31:0] MEPC,
    output logic [11:0] CSR_WADDR,
    output logic [31:0] CSR_WDATA,
    output logic        BUSY,
    output logic        FLUSH,
    output logic        REDIRECT_VALID,
    output logic [31:0] REDIRECT_PC
);

    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;
    localparam logic [11:0] CSR_MTVAL  = 12'h343;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_MEPC,
        S_W_MCAUSE,
`ifdef TRAP_SEQ_MTVAL_EN
        S_W_MTVAL,
`endif
        S_TRAP_REDIR,
        S_MRET_REDIR
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] cause_q;
`ifdef TRAP_SEQ_MTVAL_EN
    logic [31:0] tval_q;
`endif

    // Redirect targets are word aligned; the low mode bits are never used.
`ifdef TRAP_SEQ_MTVAL_EN
    logic unused_ok;
    assign unused_ok = ^{MTVEC[1:0], MEPC[1:0]};
`else
    logic unused_ok;
    assign unused_ok = ^{MTVEC[1:0], MEPC[1:0], WB_TRAP_TVAL};
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cause_q <= '0;
`ifdef TRAP_SEQ_MTVAL_EN
            tval_q  <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Trap has priority over a simultaneous mret.
                    if (WB_TRAP_VALID) begin
                        state_q <= S_W_MEPC;
                        pc_q    <= WB_TRAP_PC;
                        cause_q <= {WB_TRAP_IS_INT, WB_TRAP_CAUSE};
`ifdef TRAP_SEQ_MTVAL_EN
                        tval_q  <= WB_TRAP_TVAL;
`endif
                    end else if (WB_MRET) begin
                        state_q <= S_MRET_REDIR;
                    end
                end
                S_W_MEPC:   state_q <= S_W_MCAUSE;
`ifdef TRAP_SEQ_MTVAL_EN
                S_W_MCAUSE: state_q <= S_W_MTVAL;
                S_W_MTVAL:  state_q <= S_TRAP_REDIR;
`else
                S_W_MCAUSE: state_q <= S_TRAP_REDIR;
`endif
                default:    state_q <= S_IDLE;
            endcase
        end
    end

    // Outputs decode the registered state only; the IDLE pass-through of the
    // CSR instruction write is the one deliberately combinational path.
    always_comb begin
        CSR_WADDR      = '0;
        CSR_WDATA      = '0;
        BUSY           = 1'b1;
        FLUSH          = 1'b1;
        REDIRECT_VALID = 1'b0;
        REDIRECT_PC    = '0;
        case (state_q)
            S_IDLE: begin
                BUSY      = 1'b0;
                FLUSH     = 1'b0;
                // A trapping instruction must not commit its CSR write.
                CSR_WADDR = WB_TRAP_VALID ? 12'h000 : WB_CSR_WADDR;
                CSR_WDATA = WB_CSR_WDATA;
            end
            S_W_MEPC: begin
                CSR_WADDR = CSR_MEPC;
                CSR_WDATA = pc_q;
            end
            S_W_MCAUSE: begin
                CSR_WADDR = CSR_MCAUSE;
                CSR_WDATA = cause_q;
            end
`ifdef TRAP_SEQ_MTVAL_EN
            S_W_MTVAL: begin
                CSR_WADDR = CSR_MTVAL;
                CSR_WDATA = tval_q;
            end
`endif
            S_TRAP_REDIR: begin
                REDIRECT_VALID = 1'b1;
                REDIRECT_PC    = {MTVEC[31:2], 2'b00};
            end
            S_MRET_REDIR: begin
                REDIRECT_VALID = 1'b1;
                REDIRECT_PC    = {MEPC[31:2], 2'b00};
            end
            default: ;
        endcase
    end

endmodule
